port_arbiter3: RTL and testbench
================================

# port_arbiter3

Round-robin arbiter that shares a single Nbits-wide datapath port among three requesters. Each requester has its own req/gnt handshake, and the arbiter drives the 3:1 selector of a `mux3_1` instance. The selected word is captured into a registered output stage with a valid/ready handshake toward the consumer, for example the register-file write port or the memory request path. The block sits between the pipeline stages that compete for the port and the port itself.

## Interface
- `Nbits`, 16, data width of each requester word and of `out_data`
- `clk`  in  1  sole clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  3  request per requester; bit 0 = requester 1, bit 2 = requester 3
- `in1`, `in2`, `in3`  in  Nbits  requester data words
- `gnt`  out  3  one-hot or zero; `gnt[i]` = requester i's word is captured at this clock edge
- `out_valid`  out  1  `out_data`/`out_src` hold an unconsumed word
- `out_ready`  in  1  consumer accepts the word at this edge when `out_valid` is also high
- `out_data`  out  Nbits  captured word
- `out_src`  out  2  selector code of the captured word's source

## Operation
- Selector encoding:
  - 2'b00 = in1, 2'b01 = in2, 2'b10 = in3.
  - 2'b11 is never produced.
- `free` = `!out_valid || out_ready`. The output stage can load this cycle.
- Winner selection:
  - Combinational, only when `free` and `|req`.
  - Scan starts at priority pointer `ptr` (0..2) and proceeds in order `ptr`, `ptr+1`, `ptr+2` mod 3.
  - The first set `req` bit wins.
- `gnt`:
  - One-hot at the winner when `free && |req`; else 3'b000.
  - Combinational from `req`, `ptr`, `out_valid`, `out_ready`.
- On an edge with `gnt != 0`:
  - `out_data` <= winning input, taken through `mux3_1` with selector = winner code.
  - `out_src` <= winner code, `out_valid` <= 1.
  - `ptr` <= (winner + 1) mod 3.
- On an edge with `out_valid && out_ready && gnt == 0`: `out_valid` <= 0. `out_data`/`out_src` retain their values.
- On an edge with `out_valid && !out_ready`: all state holds. `gnt` is 0.
- Two states, encoded by `out_valid`:
  - EMPTY -> FULL on any grant.
  - FULL -> FULL on grant.
  - FULL -> EMPTY on consume with no grant.
  - FULL holds under backpressure.
- Requester contract:
  - Hold `req` and data stable until the cycle `gnt[i]` is high.
  - Deassert or present the next word in the following cycle.
  - A requester holding `req` continuously gets at most one grant in every three grants while others request.
- Simultaneous consume and grant: both happen at the same edge. The new word replaces the old one, and `out_valid` stays 1.
- Reset values: `out_valid` 0, `out_data` 0, `out_src` 2'b00, `ptr` 0 (requester 1 highest priority). `gnt` is 0 because it follows from the reset state with `req` = 0.
- Reset mid-operation: a pending unconsumed word is discarded and `ptr` returns to 0. `gnt` during the `rst` cycle is forced to 0, so no capture happens on the reset edge.

## Timing
- Latency: req seen in cycle N with `free` -> `gnt` high in N -> `out_valid`/`out_data` valid in N+1.
- Throughput: one word per cycle while `out_ready` stays high and any `req` is set.
- No combinational path from `in1`..`in3` to any output.
- `out_ready` -> `gnt` is a combinational path. The consumer must not derive `out_ready` from `gnt`.

## Structure
- Shared package `arb_pkg`:
  - Selector code constants `SEL_IN1`, `SEL_IN2`, `SEL_IN3`.
  - A `next_rr(ptr)` mod-3 increment function.
- Sub-module: reuse existing `mux3_1 #(.Nbits(Nbits))` for the data path. The arbiter feeds its selector with the winner code.
- Target size 120–200 lines.

## Test plan
- Reset: assert `rst` 2 cycles with `req`=3'b111. `gnt`=0 throughout, and after release `out_valid`=0, `out_data`=0, `out_src`=0.
- Single request: `req`=3'b010, `in2`=16'h0F00, `out_ready`=1. `gnt`=3'b010 in the same cycle. Next cycle `out_valid`=1, `out_data`=16'h0F00, `out_src`=2'b01.
- Fairness:
  - Stimulus: `req`=3'b111 held, `in1`/`in2`/`in3`=16'hF000/16'h0F00/16'h00F0, `out_ready`=1.
  - Expected: grants 001, 010, 100, 001… each cycle, with `out_data` sequence F000, 0F00, 00F0, F000.
- Backpressure: FULL with `out_ready`=0 for 4 cycles while `req`=3'b101. `gnt`=0, `out_data` stable. Raising `out_ready` grants exactly one word in that same cycle.
- Pointer carry-over:
  - Stimulus: grant requester 3, then idle, then `req`=3'b011.
  - Expected: requester 1 wins first (`ptr`=0 after winner 3), then requester 2.
- Reset mid-operation: assert `rst` while `out_valid`=1 and `out_ready`=0. The next cycle has `out_valid`=0 and `ptr`=0, and the held word is never accepted.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the three-way port arbiter: selector codes,
// output-stage state encoding and the round-robin pointer increment.
package arb_pkg;

   typedef logic [1:0] sel_t;

   localparam sel_t SEL_IN1 = 2'b00;
   localparam sel_t SEL_IN2 = 2'b01;
   localparam sel_t SEL_IN3 = 2'b10;

   // Output stage occupancy; the FULL state is what out_valid reports.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   // Mod-3 increment over the selector codes (SEL_IN3 wraps to SEL_IN1).
   function automatic sel_t next_rr(input sel_t p);
      return (p == SEL_IN3) ? SEL_IN1 : sel_t'(p + 2'd1);
   endfunction

endpackage

// File: rtl/mux3_1.sv
// 3:1 word selector driven by a 2-bit selector code.
module mux3_1
   import arb_pkg::*;
#(
   parameter int Nbits = 16
) (
   input  logic [1:0]       sel,
   input  logic [Nbits-1:0] in1,
   input  logic [Nbits-1:0] in2,
   input  logic [Nbits-1:0] in3,
   output logic [Nbits-1:0] out
);

   // Select the word named by sel; the unused code yields zero.
   always_comb begin
      // NOTE: out gets a value before the case so no path leaves it unassigned (no latch).
      out = '0;
      unique case (sel)
         SEL_IN1: out = in1;
         SEL_IN2: out = in2;
         SEL_IN3: out = in3;
         default: out = '0;
      endcase
   end

endmodule

// File: rtl/port_arbiter3.sv
// Round-robin arbiter sharing one Nbits-wide port among three requesters,
// with a single registered output word under a valid/ready handshake.
module port_arbiter3
   import arb_pkg::*;
#(
   parameter int Nbits = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       req,
   input  logic [Nbits-1:0] in1,
   input  logic [Nbits-1:0] in2,
   input  logic [Nbits-1:0] in3,
   output logic [2:0]       gnt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [Nbits-1:0] out_data,
   output logic [1:0]       out_src
);

   state_t           r_state;
   state_t           w_state_next;
   sel_t             r_ptr;
   logic [Nbits-1:0] r_data;
   sel_t             r_src;

   logic             w_free;
   logic             w_grant;
   sel_t             w_win;
   logic [2:0]       w_gnt;
   logic [Nbits-1:0] w_mux_out;

   // The stage can load when it is empty or its word leaves at this edge.
   assign w_free = (r_state == ST_EMPTY) || out_ready;

   // Scan requests from the priority pointer and pick the first one set.
   always_comb begin
      sel_t v_cand;
      w_grant = 1'b0;
      w_win   = r_ptr;
      v_cand  = r_ptr;
      if (!rst && w_free) begin
         for (int k = 0; k < 3; k++) begin
            if (!w_grant && req[v_cand]) begin
               w_grant = 1'b1;
               w_win   = v_cand;
            end
            v_cand = next_rr(v_cand);
         end
      end
      w_gnt = w_grant ? (3'b001 << w_win) : 3'b000;
   end

   mux3_1 #(.Nbits(Nbits)) u_mux (
      .sel (w_win),
      .in1 (in1),
      .in2 (in2),
      .in3 (in3),
      .out (w_mux_out)
   );

   // Output stage next state: any grant fills it, a consume without grant empties it.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         ST_EMPTY: if (w_grant) w_state_next = ST_FULL;
         ST_FULL: begin
            if (w_grant)        w_state_next = ST_FULL;
            else if (out_ready) w_state_next = ST_EMPTY;
         end
         default: w_state_next = ST_EMPTY;
      endcase
   end

   // Output stage state register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) r_state <= ST_EMPTY;
      else     r_state <= w_state_next;
   end

   // Capture the granted word and advance the pointer past the winner.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data <= '0;
         r_src  <= SEL_IN1;
         r_ptr  <= SEL_IN1;
      end else if (w_grant) begin
         r_data <= w_mux_out;
         r_src  <= w_win;
         r_ptr  <= next_rr(w_win);
      end
   end

   assign gnt       = w_gnt;
   assign out_valid = (r_state == ST_FULL);
   assign out_data  = r_data;
   assign out_src   = r_src;

endmodule

// File: tb/tb_port_arbiter3.sv
// Self-checking bench for port_arbiter3: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_port_arbiter3;

   localparam int Nbits = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic [2:0]       req;
   logic [Nbits-1:0] in1, in2, in3;
   logic [2:0]       gnt;
   logic             out_valid;
   logic             out_ready;
   logic [Nbits-1:0] out_data;
   logic [1:0]       out_src;

   int n_pass  = 0;
   int n_total = 0;

   // Behavioural model state.
   int               m_ptr   = 0;
   bit               m_valid = 0;
   logic [Nbits-1:0] m_data  = '0;
   int               m_src   = 0;

   always #5 clk = ~clk;

   port_arbiter3 #(.Nbits(Nbits)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .in1       (in1),
      .in2       (in2),
      .in3       (in3),
      .gnt       (gnt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_src   (out_src)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
   endtask

   // One clock: drive inputs, check the grant, let the edge happen, check the outputs.
   task automatic cycle(input bit r, input logic [2:0] rq, input logic [Nbits-1:0] d1,
                        input logic [Nbits-1:0] d2, input logic [Nbits-1:0] d3, input bit rdy);
      int win;
      logic [Nbits-1:0] words [3];
      @(negedge clk);
      rst = r; req = rq; in1 = d1; in2 = d2; in3 = d3; out_ready = rdy;
      words[0] = d1; words[1] = d2; words[2] = d3;
      win = -1;
      if (!r && (!m_valid || rdy)) begin
         for (int k = 0; k < 3; k++) begin
            if (win < 0 && rq[(m_ptr + k) % 3]) win = (m_ptr + k) % 3;
         end
      end
      #1;
      check("gnt", {29'd0, gnt}, (win < 0) ? 32'd0 : (32'd1 << win));
      @(posedge clk);
      if (r) begin
         m_valid = 0; m_data = '0; m_src = 0; m_ptr = 0;
      end else if (win >= 0) begin
         m_valid = 1; m_data = words[win]; m_src = win; m_ptr = (win + 1) % 3;
      end else if (m_valid && rdy) begin
         m_valid = 0;
      end
      #1;
      check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      check("out_data", {16'd0, out_data}, {16'd0, m_data});
      check("out_src", {30'd0, out_src}, m_src);
   endtask

   initial begin
      rst = 1'b1; req = '0; in1 = '0; in2 = '0; in3 = '0; out_ready = 1'b0;

      // Reset held two cycles with every requester asking.
      cycle(1, 3'b111, 16'h1111, 16'h2222, 16'h3333, 1);
      cycle(1, 3'b111, 16'h1111, 16'h2222, 16'h3333, 1);
      cycle(0, 3'b000, 16'h0, 16'h0, 16'h0, 1);

      // Single request from requester 2.
      cycle(0, 3'b010, 16'hAAAA, 16'h0F00, 16'hBBBB, 1);
      cycle(0, 3'b000, 16'h0, 16'h0, 16'h0, 1);

      // Fairness from a fresh pointer; out_data should run F000, 0F00, 00F0, F000.
      cycle(1, 3'b000, 16'h0, 16'h0, 16'h0, 1);
      for (int i = 0; i < 6; i++) cycle(0, 3'b111, 16'hF000, 16'h0F00, 16'h00F0, 1);
      check("fair_last_src", {30'd0, out_src}, 32'd2);

      // Backpressure: fill, stall 4 cycles, then release.
      cycle(0, 3'b101, 16'h1234, 16'h0, 16'h5678, 1);
      for (int i = 0; i < 4; i++) cycle(0, 3'b101, 16'h1234, 16'h0, 16'h5678, 0);
      cycle(0, 3'b101, 16'h1234, 16'h0, 16'h5678, 1);
      cycle(0, 3'b000, 16'h0, 16'h0, 16'h0, 1);

      // Pointer carry-over after requester 3 wins.
      cycle(1, 3'b000, 16'h0, 16'h0, 16'h0, 1);
      cycle(0, 3'b100, 16'h0, 16'h0, 16'hC003, 1);
      cycle(0, 3'b000, 16'h0, 16'h0, 16'h0, 1);
      cycle(0, 3'b011, 16'hC001, 16'hC002, 16'h0, 1);
      cycle(0, 3'b010, 16'hC001, 16'hC002, 16'h0, 1);
      cycle(0, 3'b000, 16'h0, 16'h0, 16'h0, 1);

      // Reset while a word sits unconsumed under backpressure.
      cycle(0, 3'b010, 16'h0, 16'hD00D, 16'h0, 1);
      cycle(0, 3'b000, 16'h0, 16'h0, 16'h0, 0);
      cycle(1, 3'b000, 16'h0, 16'h0, 16'h0, 0);
      cycle(0, 3'b111, 16'hE001, 16'hE002, 16'hE003, 1);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 49) == 0), 3'($urandom), 16'($urandom), 16'($urandom),
               16'($urandom), ($urandom_range(0, 9) < 7));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
